// File: rtl/aes_stream_controller.sv
// rtl/aes_stream_controller.sv - command sequencer between the input FIFO, an external AES core and a valid/ready result stream
module aes_stream_controller #(
    parameter int BLK_W      = 128,
    parameter int KEY_W      = 128,
    parameter int IN_ADDR_W  = 9,
    parameter int SWAP_BYTES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [31:0]          cmd,
    input  logic [IN_ADDR_W-1:0] blk_cnt,
    input  logic [BLK_W-1:0]     in_data,
    output logic                 in_r_e,
    output logic [IN_ADDR_W-1:0] in_addr,
    output logic                 core_start,
    output logic [1:0]           core_op,
    output logic [KEY_W-1:0]     core_key,
    output logic [BLK_W-1:0]     core_din,
    input  logic [BLK_W-1:0]     core_dout,
    input  logic                 core_done,
    output logic [BLK_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int                   KEY_BLKS   = KEY_W / BLK_W;
    localparam logic [IN_ADDR_W-1:0] KEY_BLKS_A = IN_ADDR_W'(KEY_BLKS);
    localparam logic [IN_ADDR_W-1:0] ONE_A      = IN_ADDR_W'(1);
    localparam logic [1:0]           OP_KEY     = 2'd0;
    localparam logic [1:0]           OP_ENC     = 2'd1;
    localparam logic [1:0]           OP_DEC     = 2'd2;
    localparam logic [1:0]           OP_IV      = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_START, S_WAIT, S_OUT, S_FINISH
    } state_t;

    state_t                 r_state, w_next;
    logic [1:0]             r_op;
    logic                   r_cbc;
    logic                   r_rej;
    logic [IN_ADDR_W-1:0]   r_cnt;
    logic [IN_ADDR_W-1:0]   r_idx;
    logic [BLK_W-1:0]       r_iv;
    logic [BLK_W-1:0]       r_next_iv;
    logic [BLK_W-1:0]       r_din;
    logic [BLK_W-1:0]       r_out_data;
    logic [KEY_W-1:0]       r_key;
    logic                   r_key_valid;
    logic                   w_rej;
    logic                   w_last;
    logic [BLK_W-1:0]       w_blk;
    logic                   w_unused_cmd;

    // Byte-reverse every 32-bit word; identity when swapping is disabled.
    function automatic logic [BLK_W-1:0] f_swap(input logic [BLK_W-1:0] d);
        logic [BLK_W-1:0] s;
        s = d;
        if (SWAP_BYTES != 0) begin
            for (int w = 0; w < BLK_W / 32; w++)
                s[w*32 +: 32] = {d[w*32 +: 8], d[w*32+8 +: 8], d[w*32+16 +: 8], d[w*32+24 +: 8]};
        end
        return s;
    endfunction

    assign w_unused_cmd = ^cmd[31:3];
    assign w_blk        = f_swap(in_data);
    assign w_last       = (r_idx == r_cnt - ONE_A);

    always_comb begin
        w_rej = 1'b0;
        case (cmd[1:0])
            OP_KEY:  w_rej = (blk_cnt != KEY_BLKS_A);
            OP_IV:   w_rej = (blk_cnt != ONE_A);
            default: w_rej = !r_key_valid;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (en) w_next = (w_rej || blk_cnt == '0) ? S_FINISH : S_READ;
            S_READ:   w_next = S_LATCH;
            S_LATCH: begin
                if (r_op == OP_IV)                  w_next = S_FINISH;
                else if (r_op == OP_KEY && !w_last) w_next = S_READ;
                else                                w_next = S_START;
            end
            S_START:  w_next = S_WAIT;
            S_WAIT:   if (core_done) w_next = (r_op == OP_KEY) ? S_FINISH : S_OUT;
            S_OUT:    if (out_ready) w_next = w_last ? S_FINISH : S_READ;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_KEY;
            r_cbc       <= 1'b0;
            r_rej       <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_iv        <= '0;
            r_next_iv   <= '0;
            r_din       <= '0;
            r_out_data  <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (en) begin
                    r_op  <= cmd[1:0];
                    r_cbc <= cmd[2];
                    r_cnt <= blk_cnt;
                    r_idx <= '0;
                    r_rej <= w_rej;
                    if (!w_rej && cmd[1:0] == OP_KEY) r_key_valid <= 1'b0;
                end
                S_LATCH: begin
                    case (r_op)
                        OP_KEY: begin
                            // Block 0 carries the most significant key half.
                            for (int i = 0; i < KEY_BLKS; i++)
                                if (r_idx == IN_ADDR_W'(i))
                                    r_key[(KEY_BLKS-1-i)*BLK_W +: BLK_W] <= w_blk;
                            if (!w_last) r_idx <= r_idx + ONE_A;
                        end
                        OP_IV:  r_iv <= w_blk;
                        OP_ENC: r_din <= r_cbc ? (w_blk ^ r_iv) : w_blk;
                        default: begin
                            r_din     <= w_blk;
                            r_next_iv <= w_blk;
                        end
                    endcase
                end
                S_WAIT: if (core_done) begin
                    if (r_op == OP_KEY) begin
                        r_key_valid <= 1'b1;
                    end else if (r_op == OP_ENC) begin
                        r_out_data <= f_swap(core_dout);
                        if (r_cbc) r_iv <= core_dout;
                    end else begin
                        r_out_data <= f_swap(r_cbc ? (core_dout ^ r_iv) : core_dout);
                        if (r_cbc) r_iv <= r_next_iv;
                    end
                end
                S_OUT: if (out_ready && !w_last) r_idx <= r_idx + ONE_A;
                default: ;
            endcase
        end
    end

    assign in_r_e     = (r_state == S_READ);
    assign in_addr    = r_idx;
    assign core_start = (r_state == S_START);
    assign core_op    = (r_op == OP_IV) ? OP_KEY : r_op;
    assign core_key   = r_key;
    assign core_din   = r_din;
    assign out_data   = r_out_data;
    assign out_valid  = (r_state == S_OUT);
    assign out_last   = (r_state == S_OUT) && w_last;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FINISH);
    assign err        = (r_state == S_FINISH) && r_rej;

endmodule

// File: tb/tb_aes_stream_controller.sv
// tb/tb_aes_stream_controller.sv - self-checking bench with a toy invertible core and a block-level reference model
module tb_aes_stream_controller;

    localparam int BW = 128;
    localparam int KW = 128;
    localparam int AW = 9;

    logic          clk = 1'b0, reset = 1'b1, en = 1'b0;
    logic [31:0]   cmd = '0;
    logic [AW-1:0] blk_cnt = '0;
    logic [BW-1:0] in_data = '0;
    logic          in_r_e, core_start, out_valid, out_last, busy, done, err;
    logic [AW-1:0] in_addr;
    logic [1:0]    core_op;
    logic [KW-1:0] core_key;
    logic [BW-1:0] core_din, out_data;
    logic [BW-1:0] core_dout = '0;
    logic          core_done = 1'b0;
    logic          out_ready = 1'b0;

    aes_stream_controller #(.BLK_W(BW), .KEY_W(KW), .IN_ADDR_W(AW), .SWAP_BYTES(1)) dut (
        .clk(clk), .reset(reset), .en(en), .cmd(cmd), .blk_cnt(blk_cnt), .in_data(in_data),
        .in_r_e(in_r_e), .in_addr(in_addr), .core_start(core_start), .core_op(core_op),
        .core_key(core_key), .core_din(core_din), .core_dout(core_dout), .core_done(core_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] swp(input logic [127:0] d);
        logic [127:0] s;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                s[w*32 + b*8 +: 8] = d[w*32 + (3-b)*8 +: 8];
        return s;
    endfunction
    function automatic logic [127:0] enc_f(input logic [127:0] x, input logic [127:0] k);
        return {x[114:0], x[127:115]} ^ k;
    endfunction
    function automatic logic [127:0] dec_f(input logic [127:0] y, input logic [127:0] k);
        logic [127:0] t;
        t = y ^ k;
        return {t[12:0], t[127:13]};
    endfunction

    // Input FIFO: data appears the cycle after the read enable.
    logic [127:0] mem [0:511];
    always @(posedge clk) if (in_r_e) in_data <= mem[in_addr];

    // Toy core with random 1..4 cycle latency.
    logic [1:0]   exp_core_op = 2'd0;
    logic [1:0]   c_op;
    logic [127:0] c_din, c_key;
    int           c_lat;
    initial begin
        forever begin
            @(negedge clk);
            if (core_start && !reset) begin
                chk("core_op", core_op, exp_core_op);
                c_op = core_op; c_din = core_din; c_key = core_key;
                c_lat = $urandom_range(1, 4);
                repeat (c_lat) @(negedge clk);
                core_done = 1'b1;
                core_dout = (c_op == 2'd1) ? enc_f(c_din, c_key) :
                            (c_op == 2'd2) ? dec_f(c_din, c_key) : {4{$urandom}};
                @(negedge clk);
                core_done = 1'b0;
                core_dout = {4{$urandom}};
            end
        end
    end

    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Output monitor
    logic [128:0] got_q[$];
    int           rd_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic         prev_stall = 1'b0, prev_last = 1'b0, prev_hs_last = 1'b0;
    logic [127:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_hs_last = 1'b0;
        end else begin
            if (in_r_e) begin
                chk("in_addr", in_addr, rd_cnt);
                rd_cnt++;
            end
            if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (prev_hs_last) chk("done_after_last", done, 1'b1);
            if (err) chk("err_with_done", done, 1'b1);
            if (out_valid && out_ready) got_q.push_back({out_last, out_data});
            if (done) done_cnt++;
            if (err) err_cnt++;
            prev_stall   = out_valid && !out_ready;
            prev_hs_last = out_valid && out_ready && out_last;
            prev_last    = out_last;
            prev_data    = out_data;
        end
    end

    // Reference model at block level
    logic [127:0] m_key = '0, m_iv = '0;
    logic         m_kv = 1'b0, m_err = 1'b0;
    int           m_reads = 0;
    logic [128:0] exp_q[$];
    task automatic model_cmd(input logic [1:0] op, input logic cbc, input int n);
        logic [127:0] x, c;
        exp_q.delete();
        m_err = (op == 2'd0 || op == 2'd3) ? (n != 1) : !m_kv;
        m_reads = m_err ? 0 : n;
        if (m_err) return;
        case (op)
            2'd0: begin m_key = swp(mem[0]); m_kv = 1'b1; end
            2'd3: m_iv = swp(mem[0]);
            2'd1: for (int i = 0; i < n; i++) begin
                x = swp(mem[i]);
                if (cbc) x = x ^ m_iv;
                c = enc_f(x, m_key);
                if (cbc) m_iv = c;
                exp_q.push_back({i == n - 1, swp(c)});
            end
            default: for (int i = 0; i < n; i++) begin
                c = swp(mem[i]);
                x = dec_f(c, m_key);
                if (cbc) begin x = x ^ m_iv; m_iv = c; end
                exp_q.push_back({i == n - 1, swp(x)});
            end
        endcase
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic cbc, input int n);
        model_cmd(op, cbc, n);
        got_q.delete();
        rd_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_core_op = (op == 2'd3) ? 2'd0 : op;
        @(negedge clk);
        en = 1'b1;
        cmd = $urandom;
        cmd[2:0] = {cbc, op};
        blk_cnt = AW'(n);
        @(negedge clk);
        en = 1'b0;
        if (m_err || n == 0) chk("early_done", {done, err, in_r_e}, {1'b1, m_err, 1'b0});
        else                 chk("first_read", {in_r_e, in_addr}, {1'b1, 9'd0});
    endtask

    task automatic finish_cmd(input logic xerr);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin @(negedge clk); t++; end
        if (done_cnt == 0) begin
            bad++; total++;
            $display("FAIL timeout: no done within 3000 cycles");
        end
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("err", err_cnt, xerr);
        chk("reads", rd_cnt, m_reads);
        chk("nblocks", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("block", got_q[i], exp_q[i]);
    endtask

    task automatic reset_outs_chk();
        chk("rst_ctrl", {in_r_e, in_addr, core_start, core_op, out_valid, out_last, busy, done, err}, '0);
        chk("rst_key", core_key, '0);
        chk("rst_din", core_din, '0);
        chk("rst_out", out_data, '0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic       cbc;
        int         n;
        logic       exp_err;
    } vec_t;

    vec_t         tbl[11];
    logic [127:0] pt[3];
    logic [127:0] ivraw, cap;
    int           t;
    logic [1:0]   rop;
    logic         rcbc;
    int           rn;

    initial begin
        tbl[0]  = '{2'd1, 1'b0, 2, 1'b1};
        tbl[1]  = '{2'd0, 1'b0, 1, 1'b0};
        tbl[2]  = '{2'd0, 1'b0, 2, 1'b1};
        tbl[3]  = '{2'd3, 1'b0, 2, 1'b1};
        tbl[4]  = '{2'd3, 1'b0, 1, 1'b0};
        tbl[5]  = '{2'd1, 1'b0, 3, 1'b0};
        tbl[6]  = '{2'd1, 1'b1, 4, 1'b0};
        tbl[7]  = '{2'd2, 1'b0, 2, 1'b0};
        tbl[8]  = '{2'd2, 1'b1, 3, 1'b0};
        tbl[9]  = '{2'd1, 1'b1, 0, 1'b0};
        tbl[10] = '{2'd2, 1'b0, 1, 1'b0};

        repeat (3) @(negedge clk);
        reset_outs_chk();
        reset = 1'b0;

        foreach (tbl[i]) begin
            fill(tbl[i].n);
            start_cmd(tbl[i].op, tbl[i].cbc, tbl[i].n);
            finish_cmd(tbl[i].exp_err);
        end

        // en -> read -> capture -> core_start latency
        fill(1);
        start_cmd(2'd1, 1'b0, 1);
        @(negedge clk);
        chk("k2_no_read", {in_r_e, core_start}, 2'b00);
        @(negedge clk);
        chk("k3_start", core_start, 1'b1);
        finish_cmd(1'b0);

        // CBC round trip: decrypting the ciphertext under the same IV restores the plaintext
        ivraw = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = ivraw;
        start_cmd(2'd3, 1'b0, 1); finish_cmd(1'b0);
        fill(3);
        for (int i = 0; i < 3; i++) pt[i] = mem[i];
        start_cmd(2'd1, 1'b1, 3); finish_cmd(1'b0);
        for (int i = 0; i < 3; i++) mem[i] = got_q[i][127:0];
        mem[3] = ivraw;
        mem[0] = ivraw;
        start_cmd(2'd3, 1'b0, 1); finish_cmd(1'b0);
        for (int i = 0; i < 3; i++) mem[i] = exp_q.size() == 0 ? mem[i] : mem[i];
        for (int i = 0; i < 3; i++) mem[i] = swp(enc_f(swp(pt[i]) ^ (i == 0 ? swp(ivraw) : enc_f(swp(pt[i-1]) ^ (i == 1 ? swp(ivraw) : enc_f(swp(pt[0]) ^ swp(ivraw), m_key)), m_key)), m_key));
        start_cmd(2'd2, 1'b1, 3); finish_cmd(1'b0);
        for (int i = 0; i < 3 && i < got_q.size(); i++) chk("roundtrip", got_q[i][127:0], pt[i]);

        // Backpressure: sink stalls 10 cycles on block 0 of 3
        ready_mode = 2;
        fill(3);
        start_cmd(2'd1, 1'b0, 3);
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        cap = out_data;
        repeat (10) begin
            @(negedge clk);
            chk("stall", {out_valid, in_r_e, out_data}, {1'b1, 1'b0, cap});
        end
        ready_mode = 0;
        finish_cmd(1'b0);

        // en pulses while busy must not start anything
        fill(3);
        start_cmd(2'd1, 1'b1, 3);
        repeat (3) begin
            en = 1'b1; @(negedge clk);
            en = 1'b0; @(negedge clk);
        end
        finish_cmd(1'b0);

        // Reset in WAIT aborts without done
        fill(2);
        start_cmd(2'd1, 1'b0, 2);
        t = 0;
        while (!core_start && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("in_wait", {busy, core_start, out_valid}, 3'b100);
        reset = 1'b1;
        @(negedge clk);
        reset_outs_chk();
        reset = 1'b0;
        m_kv = 1'b0; m_key = '0; m_iv = '0;
        done_cnt = 0;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", done_cnt, 0);
        fill(1);
        start_cmd(2'd1, 1'b0, 1); finish_cmd(1'b1);
        fill(1);
        start_cmd(2'd0, 1'b0, 1); finish_cmd(1'b0);
        fill(2);
        start_cmd(2'd1, 1'b1, 2); finish_cmd(1'b0);

        // Randomised commands with a randomly stalling sink
        ready_mode = 1;
        for (int r = 0; r < 25; r++) begin
            rop  = 2'($urandom_range(0, 3));
            rcbc = 1'($urandom_range(0, 1));
            rn   = (rop == 2'd0 || rop == 2'd3) ? $urandom_range(0, 2) : $urandom_range(0, 5);
            fill(rn);
            start_cmd(rop, rcbc, rn);
            finish_cmd(m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

endmodule
